mem_stage_ctrl: RTL and testbench

MEM-stage controller of the five-stage pipeline: consumes the EX/MEM pipeline register fields, runs load/store accesses on a req/ack data-memory port with a bounded wait, and resolves branches. It also stalls the upstream pipeline registers while an access is outstanding and drives the MEM/WB register fields, which are valid for exactly one cycle per instruction.

---
 rtl/mem_stage_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller of the five-stage pipeline.
// Issues load/store accesses on a req/ack data-memory port with a bounded
// wait, stalls upstream while an access is in flight, resolves branches and
// drives the MEM/WB register fields (valid for one cycle per instruction).
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject word-misaligned accesses).
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  input  logic        branch_in,
  input  logic        zflag_in,
  input  logic [31:0] branch_result_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] data2_in,
  input  logic [4:0]  instruccion_in,
  output logic        stall_out,
  output logic        pcsrc_out,
  output logic [31:0] pc_target_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic [31:0] readdata_out,
  output logic [31:0] alures_out,
  output logic [4:0]  instruccion_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The abort fires in the cycle whose count is TIMEOUT-1, so the request is
  // held for exactly TIMEOUT cycles; an ack in that same cycle still wins.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d, state_eff;
  logic [7:0]  cnt_q, cnt_d;
  logic        lat_regwrite_q, lat_regwrite_d;
  logic        lat_memtoreg_q, lat_memtoreg_d;
  logic [4:0]  lat_instr_q, lat_instr_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] alures_q, alures_d;
  logic [4:0]  instr_q, instr_d;
  logic        err_q, err_d;
  logic        memop;
  logic        misalign;

  assign memop = memread_in | memwrite_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (alures_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign pc_target_out   = branch_result_in;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign regwrite_out    = regwrite_q;
  assign memtoreg_out    = memtoreg_q;
  assign readdata_out    = readdata_q;
  assign alures_out      = alures_q;
  assign instruccion_out = instr_q;
  assign err_out         = err_q;

  // Combinational stall/branch outputs; while reset is asserted they behave as in IDLE.
  always_comb begin
    state_eff = reset ? IDLE : state_q;
    stall_out = 1'b0;
    pcsrc_out = 1'b0;
    case (state_eff)
      IDLE: begin
        stall_out = memop;
        pcsrc_out = branch_in & zflag_in;
      end
      ACCESS:  stall_out = 1'b1;
      DONE:    stall_out = 1'b0;
      default: stall_out = 1'b0;
    endcase
  end

  // Next-state, memory port and MEM/WB field computation (bubble by default).
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lat_regwrite_d = lat_regwrite_q;
    lat_memtoreg_d = lat_memtoreg_q;
    lat_instr_d    = lat_instr_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    regwrite_d     = 1'b0;
    memtoreg_d     = 1'b0;
    readdata_d     = 32'd0;
    alures_d       = 32'd0;
    instr_d        = 5'd0;
    err_d          = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          if (misalign) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            mem_req_d      = 1'b1;
            mem_we_d       = memwrite_in;  // read+write together counts as a write
            mem_addr_d     = alures_in;
            mem_wdata_d    = data2_in;
            lat_regwrite_d = regwrite_in;
            lat_memtoreg_d = memtoreg_in;
            lat_instr_d    = instruccion_in;
            cnt_d          = 8'd0;
            state_d        = ACCESS;
          end
        end else begin
          regwrite_d = regwrite_in;
          memtoreg_d = memtoreg_in;
          alures_d   = alures_in;
          instr_d    = instruccion_in;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          regwrite_d = lat_regwrite_q;
          memtoreg_d = lat_memtoreg_q;
          alures_d   = mem_addr_q;
          instr_d    = lat_instr_q;
          readdata_d = mem_we_q ? 32'd0 : mem_rdata;
          state_d    = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      lat_regwrite_q <= 1'b0;
      lat_memtoreg_q <= 1'b0;
      lat_instr_q    <= 5'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      regwrite_q     <= 1'b0;
      memtoreg_q     <= 1'b0;
      readdata_q     <= 32'd0;
      alures_q       <= 32'd0;
      instr_q        <= 5'd0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_regwrite_q <= lat_regwrite_d;
      lat_memtoreg_q <= lat_memtoreg_d;
      lat_instr_q    <= lat_instr_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      regwrite_q     <= regwrite_d;
      memtoreg_q     <= memtoreg_d;
      readdata_q     <= readdata_d;
      alures_q       <= alures_d;
      instr_q        <= instr_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4); MEM/WB results are checked
// against a scoreboard queue filled as each cycle's stimulus is driven.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in, zflag_in;
  logic [31:0] branch_result_in, alures_in, data2_in;
  logic [4:0]  instruccion_in;
  logic        stall_out, pcsrc_out;
  logic [31:0] pc_target_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        regwrite_out, memtoreg_out;
  logic [31:0] readdata_out, alures_out;
  logic [4:0]  instruccion_out;
  logic        err_out;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  ins;
  } mwb_t;

  mwb_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt;
  int   req_cnt;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .memwrite_in(memwrite_in), .memread_in(memread_in),
    .branch_in(branch_in), .zflag_in(zflag_in),
    .branch_result_in(branch_result_in), .alures_in(alures_in),
    .data2_in(data2_in), .instruccion_in(instruccion_in),
    .stall_out(stall_out), .pcsrc_out(pcsrc_out), .pc_target_out(pc_target_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out),
    .readdata_out(readdata_out), .alures_out(alures_out),
    .instruccion_out(instruccion_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_inputs(input logic rw, input logic mtr, input logic mw, input logic mr,
                            input logic br, input logic z, input logic [31:0] bres,
                            input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] ins);
    regwrite_in = rw; memtoreg_in = mtr; memwrite_in = mw; memread_in = mr;
    branch_in = br; zflag_in = z; branch_result_in = bres;
    alures_in = alu; data2_in = d2; instruccion_in = ins;
    #1;
  endtask

  task automatic push_exp(input logic rw, input logic mtr, input logic [31:0] rd,
                          input logic [31:0] alu, input logic [4:0] ins);
    mwb_t e;
    e.rw = rw; e.mtr = mtr; e.rd = rd; e.alu = alu; e.ins = ins;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble;
    push_exp(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic check_mwb(input string tag);
    mwb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty observed=empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_regwrite"}, {31'd0, regwrite_out}, {31'd0, e.rw});
      chk({tag, "_memtoreg"}, {31'd0, memtoreg_out}, {31'd0, e.mtr});
      chk({tag, "_readdata"}, readdata_out, e.rd);
      chk({tag, "_alures"},   alures_out, e.alu);
      chk({tag, "_instr"},    {27'd0, instruccion_out}, {27'd0, e.ins});
    end
  endtask

  initial begin
    // Reset with random inputs (no memory op)
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = $urandom;
    set_inputs($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b0, $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
    tick;
    tick;
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_pcsrc", {31'd0, pcsrc_out}, {31'd0, branch_in & zflag_in});
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_err", {31'd0, err_out}, 32'd0);
    push_bubble;
    check_mwb("rst_mwb");
    reset = 1'b0;

    // ALU op: MEM/WB one cycle later, no stall
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_00AA, 32'd0, 5'd5);
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
    push_exp(1'b1, 1'b0, 32'd0, 32'h0000_00AA, 5'd5);
    tick;
    check_mwb("alu_mwb");
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    push_bubble;
    tick;
    check_mwb("nop_mwb");

    // Load at 0x100, ack in the third ACCESS cycle
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0100, 32'd0, 5'd7);
    stall_cnt = 0;
    if (stall_out) stall_cnt++;
    push_bubble;
    tick;
    check_mwb("ld_issue");
    for (int c = 1; c <= 3; c++) begin
      chk("ld_req", {31'd0, mem_req}, 32'd1);
      chk("ld_addr", mem_addr, 32'h0000_0100);
      chk("ld_we", {31'd0, mem_we}, 32'd0);
      if (stall_out) stall_cnt++;
      if (c == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        push_exp(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 5'd7);
      end else begin
        push_bubble;
      end
      tick;
      check_mwb("ld_wait");
    end
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
    chk("ld_done_stall", {31'd0, stall_out}, 32'd0);
    chk("ld_stall_cycles", stall_cnt, 32'd4);
    chk("ld_err", {31'd0, err_out}, 32'd0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    push_bubble;
    tick;
    check_mwb("ld_after");

    // Store with no ack: timeout after 4 request cycles
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0200, 32'h1234_5678, 5'd9);
    push_bubble;
    tick;
    check_mwb("st_issue");
    req_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (mem_req) req_cnt++;
      chk("st_we", {31'd0, mem_we}, 32'd1);
      chk("st_wdata", mem_wdata, 32'h1234_5678);
      chk("st_err_early", {31'd0, err_out}, 32'd0);
      push_bubble;
      tick;
      check_mwb("st_wait");
    end
    chk("st_req_cycles", req_cnt, 32'd4);
    chk("st_req_drop", {31'd0, mem_req}, 32'd0);
    chk("st_err_pulse", {31'd0, err_out}, 32'd1);
    chk("st_done_stall", {31'd0, stall_out}, 32'd0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    push_bubble;
    tick;
    check_mwb("st_after");
    chk("st_err_clear", {31'd0, err_out}, 32'd0);

    // Read+write together is a write; ack in the last allowed cycle wins
    set_inputs(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0300, 32'hCAFE_F00D, 5'd3);
    push_bubble;
    tick;
    check_mwb("rw_issue");
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        push_exp(1'b1, 1'b0, 32'd0, 32'h0000_0300, 5'd3);
      end else begin
        push_bubble;
      end
      tick;
      check_mwb("rw_wait");
    end
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("rw_no_err", {31'd0, err_out}, 32'd0);
    chk("rw_req_drop", {31'd0, mem_req}, 32'd0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    push_bubble;
    tick;
    check_mwb("rw_after");

    // Branch resolution
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'd0, 32'd0, 5'd0);
    chk("br_taken", {31'd0, pcsrc_out}, 32'd1);
    chk("br_target", pc_target_out, 32'h0000_0040);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'd0, 5'd0);
    chk("br_not_taken", {31'd0, pcsrc_out}, 32'd0);
    push_bubble;
    tick;
    check_mwb("br_mwb");

    // Reset in the middle of ACCESS
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0400, 32'h0000_00FF, 5'd11);
    chk("mr_pcsrc_idle", {31'd0, pcsrc_out}, 32'd1);
    push_bubble;
    tick;
    check_mwb("mr_issue");
    chk("mr_pcsrc_access", {31'd0, pcsrc_out}, 32'd0);
    chk("mr_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_rst_pcsrc", {31'd0, pcsrc_out}, 32'd1);
    chk("mr_rst_stall", {31'd0, stall_out}, 32'd1);
    push_bubble;
    tick;
    check_mwb("mr_rst");
    chk("mr_req_zero", {31'd0, mem_req}, 32'd0);
    chk("mr_addr_zero", mem_addr, 32'd0);
    chk("mr_wdata_zero", mem_wdata, 32'd0);
    reset = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    chk("mr_idle_stall", {31'd0, stall_out}, 32'd0);
    push_bubble;
    tick;
    check_mwb("mr_after");

    // Misaligned load at 0x102
    set_inputs(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0102, 32'd0, 5'd12);
    chk("al_stall", {31'd0, stall_out}, 32'd1);
    push_bubble;
    tick;
    check_mwb("al_issue");
`ifdef MEM_ALIGN_CHECK_EN
    chk("al_no_req", {31'd0, mem_req}, 32'd0);
    chk("al_err", {31'd0, err_out}, 32'd1);
    chk("al_done_stall", {31'd0, stall_out}, 32'd0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    push_bubble;
    tick;
    check_mwb("al_after");
    chk("al_err_clear", {31'd0, err_out}, 32'd0);
    chk("al_still_no_req", {31'd0, mem_req}, 32'd0);
`else
    chk("al_req", {31'd0, mem_req}, 32'd1);
    chk("al_addr", mem_addr, 32'h0000_0102);
    mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    push_exp(1'b1, 1'b1, 32'h55AA_55AA, 32'h0000_0102, 5'd12);
    tick;
    check_mwb("al_done");
    mem_ack = 1'b0; mem_rdata = 32'd0;
    chk("al_req_drop", {31'd0, mem_req}, 32'd0);
    chk("al_err", {31'd0, err_out}, 32'd0);
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    push_bubble;
    tick;
    check_mwb("al_after");
`endif

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
